// File: rtl/pixel_stream_pkg.sv
// Shared constants and types for the pixel byte-stream blocks (assembler and serializer).
package pixel_stream_pkg;

   localparam int byte_width_lp = 8;

   typedef enum logic {
      IDLE,
      SEND
   } ser_state_e;

endpackage

// File: rtl/pixel_serializer.sv
// Pixel serializer: accepts whole pixels over valid/ready and emits them one byte per beat,
// most- or least-significant byte first, with zero-bubble handoff between back-to-back pixels.
module pixel_serializer
   import pixel_stream_pkg::*;
#(
   parameter int pixel_bytes_p = 2,
   parameter bit msb_first_p   = 1'b1
) (
   input  logic                                  clk_i,
   input  logic                                  reset_i,
   input  logic [byte_width_lp*pixel_bytes_p-1:0] pixel_i,
   input  logic                                  valid_i,
   output logic                                  ready_o,
   output logic [byte_width_lp-1:0]              data_o,
   output logic                                  valid_o,
   input  logic                                  ready_i,
   output logic                                  last_o,
   output logic                                  busy_o
);

   localparam int width_lp = byte_width_lp * pixel_bytes_p;
   localparam int cnt_w_lp = $clog2(pixel_bytes_p + 1);
   localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(pixel_bytes_p - 1);
   localparam logic [cnt_w_lp-1:0] one_cnt_lp  = cnt_w_lp'(1);

   ser_state_e            state_reg, state_next;
   logic [width_lp-1:0]   shift_reg, shift_next;
   logic [cnt_w_lp-1:0]   count_reg, count_next;
   logic [byte_width_lp-1:0] head_byte;
   logic                  sending;
   logic                  at_last;

   // The output byte always sits at one end of the shift register; which end is fixed at build time.
   generate
      if (msb_first_p) begin : g_msb_first
         assign head_byte = shift_reg[width_lp-1 -: byte_width_lp];
      end else begin : g_lsb_first
         assign head_byte = shift_reg[byte_width_lp-1:0];
      end
   endgenerate

   assign sending = (state_reg == SEND);
   assign at_last = sending && (count_reg == last_cnt_lp);

   assign valid_o = sending;
   assign busy_o  = sending;
   assign last_o  = at_last;
   assign data_o  = head_byte;

   // Accepting on the final byte's transfer lets the next pixel follow with no idle beat;
   // this is the only combinational input-to-output path (ready_i -> ready_o).
   assign ready_o = (state_reg == IDLE) || (at_last && ready_i);

   // Next-state logic: load on input transfer, shift toward the output end on non-final transfers.
   always_comb begin
      state_next = state_reg;
      shift_next = shift_reg;
      count_next = count_reg;
      case (state_reg)
         IDLE: begin
            if (valid_i) begin
               shift_next = pixel_i;
               count_next = '0;
               state_next = SEND;
            end
         end
         SEND: begin
            if (ready_i) begin
               if (at_last) begin
                  if (valid_i) begin
                     shift_next = pixel_i;
                     count_next = '0;
                  end else begin
                     state_next = IDLE;
                  end
               end else begin
                  shift_next = msb_first_p ? (shift_reg << byte_width_lp)
                                           : (shift_reg >> byte_width_lp);
                  count_next = count_reg + one_cnt_lp;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State, shift and count registers; reset drops any partially sent pixel immediately.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_reg <= IDLE;
         shift_reg <= '0;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         shift_reg <= shift_next;
         count_reg <= count_next;
      end
   end

endmodule

// File: tb/tb_pixel_serializer.sv
// Self-checking bench for pixel_serializer: three instances (P=2 MSB-first, P=3 LSB-first,
// P=1) exercised by directed scenarios and a randomized scoreboard run.
module tb_pixel_serializer;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   // Instance A: P=2, MSB first
   logic [15:0] pix_a;
   logic        vi_a, ro_a, vo_a, ri_a, last_a, busy_a;
   logic [7:0]  data_a;
   // Instance B: P=3, LSB first
   logic [23:0] pix_b;
   logic        vi_b, ro_b, vo_b, ri_b, last_b, busy_b;
   logic [7:0]  data_b;
   // Instance C: P=1
   logic [7:0]  pix_c;
   logic        vi_c, ro_c, vo_c, ri_c, last_c, busy_c;
   logic [7:0]  data_c;

   pixel_serializer #(.pixel_bytes_p(2), .msb_first_p(1'b1)) dut_a (
      .clk_i(clk), .reset_i(rst), .pixel_i(pix_a), .valid_i(vi_a), .ready_o(ro_a),
      .data_o(data_a), .valid_o(vo_a), .ready_i(ri_a), .last_o(last_a), .busy_o(busy_a));

   pixel_serializer #(.pixel_bytes_p(3), .msb_first_p(1'b0)) dut_b (
      .clk_i(clk), .reset_i(rst), .pixel_i(pix_b), .valid_i(vi_b), .ready_o(ro_b),
      .data_o(data_b), .valid_o(vo_b), .ready_i(ri_b), .last_o(last_b), .busy_o(busy_b));

   pixel_serializer #(.pixel_bytes_p(1), .msb_first_p(1'b1)) dut_c (
      .clk_i(clk), .reset_i(rst), .pixel_i(pix_c), .valid_i(vi_c), .ready_o(ro_c),
      .data_o(data_c), .valid_o(vo_c), .ready_i(ri_c), .last_o(last_c), .busy_o(busy_c));

   // Reference: k-th byte emitted for a pixel of p bytes
   function automatic logic [7:0] ref_byte(input logic [23:0] pix, input int p, input bit msb, input int k);
      int sh;
      sh = msb ? 8 * (p - 1 - k) : 8 * k;
      return 8'(pix >> sh);
   endfunction

   // Move to the drive point: 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      vi_a = 0; ri_a = 1; pix_a = '0;
      vi_b = 0; ri_b = 1; pix_b = '0;
      vi_c = 0; ri_c = 1; pix_c = '0;
      #2;
      total++;
      if ({vo_a, last_a, busy_a, data_a, vo_b, busy_b, vo_c, busy_c} !== 15'd0) begin
         bad++;
         $display("FAIL reset_outputs: got va=%b la=%b ba=%b da=%h vb=%b bb=%b vc=%b bc=%b want all 0",
                  vo_a, last_a, busy_a, data_a, vo_b, busy_b, vo_c, busy_c);
      end
      tick();
      rst = 1'b0;
      #1;
      total++;
      if ({ro_a, ro_b, ro_c, vo_a} !== 4'b1110) begin
         bad++;
         $display("FAIL reset_release_ready: got ra=%b rb=%b rc=%b va=%b want 1 1 1 0", ro_a, ro_b, ro_c, vo_a);
      end
   endtask

   task automatic test_single();
      logic [15:0] pix;
      pix = 16'hABCD;
      tick();
      vi_a = 1; pix_a = pix; ri_a = 1;
      #1;
      total++;
      if ({ro_a, vo_a} !== 2'b10) begin
         bad++;
         $display("FAIL single_accept: got ready=%b valid=%b want 1 0", ro_a, vo_a);
      end
      for (int k = 0; k < 2; k++) begin
         tick();
         vi_a = 0; pix_a = 16'($urandom);
         #1;
         total++;
         if ({vo_a, last_a, data_a} !== {1'b1, (k == 1), ref_byte(24'(pix), 2, 1'b1, k)}) begin
            bad++;
            $display("FAIL single_byte%0d: got v=%b l=%b d=%h want 1 %b %h", k, vo_a, last_a, data_a,
                     (k == 1), ref_byte(24'(pix), 2, 1'b1, k));
         end
      end
      tick();
      #1;
      total++;
      if ({vo_a, busy_a} !== 2'b00) begin
         bad++;
         $display("FAIL single_idle: got valid=%b busy=%b want 0 0", vo_a, busy_a);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] pixq[2];
      logic [7:0]  exp_d;
      pixq[0] = 16'h1234;
      pixq[1] = 16'h5678;
      tick();
      vi_a = 1; pix_a = pixq[0]; ri_a = 1;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (c == 0) begin
            pix_a = pixq[1];
         end else if (c == 2) begin
            vi_a = 0; pix_a = 16'($urandom);
         end
         #1;
         exp_d = ref_byte(24'(pixq[c / 2]), 2, 1'b1, c % 2);
         total++;
         if ({vo_a, last_a, ro_a, data_a} !== {1'b1, (c % 2 == 1), (c % 2 == 1), exp_d}) begin
            bad++;
            $display("FAIL b2b_cycle%0d: got v=%b l=%b r=%b d=%h want 1 %b %b %h", c, vo_a, last_a, ro_a,
                     data_a, (c % 2 == 1), (c % 2 == 1), exp_d);
         end
      end
      tick();
      #1;
      total++;
      if (vo_a !== 1'b0) begin
         bad++;
         $display("FAIL b2b_idle: got valid=%b want 0", vo_a);
      end
   endtask

   task automatic test_backpressure();
      tick();
      vi_a = 1; pix_a = 16'hBEEF; ri_a = 1;
      for (int c = 0; c < 3; c++) begin
         tick();
         vi_a = 1; pix_a = 16'($urandom); ri_a = 0;
         #1;
         total++;
         if ({vo_a, last_a, ro_a, data_a} !== {3'b100, 8'hBE}) begin
            bad++;
            $display("FAIL bp_hold%0d: got v=%b l=%b r=%b d=%h want 1 0 0 be", c, vo_a, last_a, ro_a, data_a);
         end
      end
      tick();
      vi_a = 0; ri_a = 1;
      #1;
      total++;
      if ({vo_a, last_a, data_a} !== {2'b10, 8'hBE}) begin
         bad++;
         $display("FAIL bp_release_be: got v=%b l=%b d=%h want 1 0 be", vo_a, last_a, data_a);
      end
      tick();
      #1;
      total++;
      if ({vo_a, last_a, data_a} !== {2'b11, 8'hEF}) begin
         bad++;
         $display("FAIL bp_release_ef: got v=%b l=%b d=%h want 1 1 ef", vo_a, last_a, data_a);
      end
      tick();
      #1;
      total++;
      if (vo_a !== 1'b0) begin
         bad++;
         $display("FAIL bp_idle: got valid=%b want 0", vo_a);
      end
   endtask

   task automatic test_lsb_first();
      logic [23:0] pix;
      logic [7:0]  exp_d;
      pix = 24'h112233;
      tick();
      vi_b = 1; pix_b = pix; ri_b = 1;
      for (int k = 0; k < 3; k++) begin
         tick();
         vi_b = 0; pix_b = 24'($urandom);
         #1;
         exp_d = ref_byte(pix, 3, 1'b0, k);
         total++;
         if ({vo_b, last_b, data_b} !== {1'b1, (k == 2), exp_d}) begin
            bad++;
            $display("FAIL lsb_byte%0d: got v=%b l=%b d=%h want 1 %b %h", k, vo_b, last_b, data_b, (k == 2), exp_d);
         end
      end
      tick();
      #1;
      total++;
      if ({vo_b, busy_b} !== 2'b00) begin
         bad++;
         $display("FAIL lsb_idle: got valid=%b busy=%b want 0 0", vo_b, busy_b);
      end
   endtask

   task automatic test_async_reset();
      tick();
      vi_a = 1; pix_a = 16'hAA55; ri_a = 1;
      tick();
      vi_a = 0;
      #1;
      total++;
      if ({vo_a, data_a} !== {1'b1, 8'hAA}) begin
         bad++;
         $display("FAIL areset_first: got v=%b d=%h want 1 aa", vo_a, data_a);
      end
      tick();
      ri_a = 0;
      #1;
      total++;
      if ({vo_a, last_a, data_a} !== {2'b11, 8'h55}) begin
         bad++;
         $display("FAIL areset_second: got v=%b l=%b d=%h want 1 1 55", vo_a, last_a, data_a);
      end
      rst = 1'b1;
      #1;
      total++;
      if ({vo_a, busy_a, last_a} !== 3'b000) begin
         bad++;
         $display("FAIL areset_immediate: got v=%b b=%b l=%b want 0 0 0", vo_a, busy_a, last_a);
      end
      #1;
      rst = 1'b0;
      ri_a = 1;
      for (int c = 0; c < 4; c++) begin
         tick();
         #1;
         total++;
         if ({vo_a, ro_a} !== 2'b01) begin
            bad++;
            $display("FAIL areset_after%0d: got v=%b r=%b d=%h want v=0 r=1", c, vo_a, ro_a, data_a);
         end
      end
   endtask

   task automatic test_random_p1();
      logic [7:0] q[$];
      logic [7:0] exp_d;
      int n_in, n_out;
      n_in = 0; n_out = 0;
      for (int c = 0; c < 1008; c++) begin
         tick();
         if (c < 1000) begin
            vi_c  = (($urandom % 10) < 7);
            ri_c  = (($urandom % 10) < 6);
            pix_c = 8'($urandom);
         end else begin
            vi_c = 0; ri_c = 1; pix_c = 8'($urandom);
         end
         #1;
         if (vo_c && ri_c) begin
            n_out++;
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL rand_extra_byte: got d=%h at cycle %0d want no output (nothing pending)", data_c, c);
            end else begin
               exp_d = q.pop_front();
               if ({last_c, data_c} !== {1'b1, exp_d}) begin
                  bad++;
                  $display("FAIL rand_byte: got l=%b d=%h at cycle %0d want 1 %h", last_c, data_c, c, exp_d);
               end
            end
         end
         if (vi_c && ro_c) begin
            q.push_back(pix_c);
            n_in++;
         end
      end
      total++;
      if (q.size() != 0 || n_in != n_out || n_in == 0) begin
         bad++;
         $display("FAIL rand_count: got out=%0d pending=%0d want out=%0d pending=0", n_out, q.size(), n_in);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_lsb_first();
      test_async_reset();
      test_random_p1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pixel_serializer.md
Name: pixel_serializer

Overview:
- Transmit-side counterpart of the pixel byte-assembly path.
- Accepts whole pixels of pixel_bytes_p bytes over a valid/ready handshake and emits them one byte per beat over a downstream valid/ready byte interface.
- Sits between a pixel source (frame buffer, test pattern generator) and a byte-wide sink (UART/SPI TX, byte FIFO).
- Sustains one byte per cycle with back-to-back pixels and no bubble between pixels.

Parameters:
- pixel_bytes_p, 2, bytes per pixel; legal values are 1 and above.
- msb_first_p, 1, 1 = most significant byte is sent first; 0 = least significant byte is sent first.

Ports:
- clk_i  input  1  single clock, rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- pixel_i  input  8*pixel_bytes_p  pixel word from upstream.
- valid_i  input  1  pixel_i is valid.
- ready_o  output  1  block can accept a pixel this cycle.
- data_o  output  8  current output byte.
- valid_o  output  1  data_o is valid.
- ready_i  input  1  downstream accepts data_o this cycle.
- last_o  output  1  data_o is the final byte of its pixel; qualified by valid_o.
- busy_o  output  1  a pixel is in progress (state is SEND).

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE, shift register = 0, byte count = 0.
  - valid_o = 0, last_o = 0, busy_o = 0, data_o = 0; ready_o = 1 once reset deasserts.
  - Reset mid-pixel discards any unsent bytes; no partial output after reset is released.
- State register, byte counter and shift register are flopped. data_o, valid_o, last_o and busy_o are decoded from flops only.
- Byte counter width is $clog2(pixel_bytes_p+1). Counts 0..pixel_bytes_p-1; never wraps past pixel_bytes_p-1.
- Transfer rules:
  - Input transfer = valid_i && ready_o.
  - Output transfer = valid_o && ready_i.
- ready_o = (state==IDLE) || (state==SEND && last_o && ready_i).
  - This is the only combinational path, from ready_i to ready_o.
  - It gives a zero-bubble pixel handoff.
- State IDLE:
  - valid_o = 0.
  - On input transfer: load pixel_i into the shift register, count = 0, go to SEND.
  - The first byte is on data_o with valid_o = 1 in the cycle after the accepting edge. Latency is 1 cycle.
- State SEND:
  - valid_o = 1.
  - data_o = shift[8P-1:8P-8] when msb_first_p=1, else shift[7:0].
  - last_o = (count == pixel_bytes_p-1).
- Output transfer, not last byte: shift by 8 toward the output end, count++.
- Output transfer, last byte, valid_i=1: load the new pixel, count = 0, stay in SEND.
- Output transfer, last byte, valid_i=0: go to IDLE; valid_o = 0 next cycle.
- No output transfer (valid_o && !ready_i):
  - data_o, last_o, count and shift register hold stable.
  - ready_o = 0, so upstream pixel_i is not sampled.
- pixel_bytes_p = 1: every byte is last; the block acts as a 1-deep registered slice.
- pixel_i is sampled only on an input transfer. Changes on pixel_i at any other time have no effect.
- Throughput: pixel_bytes_p cycles per pixel with continuous valid_i and ready_i.

Decomposition:
- Shared package pixel_stream_pkg:
  - localparam byte_width_lp = 8.
  - typedef enum logic {IDLE, SEND} ser_state_e.
  - Reused by the pixel assembler and this block for common width constants.
- No sub-module; a single module of about 150 lines.

Test Plan:
- P=2, msb_first_p=1, ready_i held 1, single pixel 0xABCD -> data_o 0xAB (last_o=0), then 0xCD (last_o=1), then valid_o=0. First byte valid 1 cycle after acceptance.
- P=2, back-to-back pixels 0x1234 and 0x5678 with valid_i held 1 -> bytes 12,34,56,78 on 4 consecutive cycles. ready_o=1 exactly in the cycle 0x34 transfers.
- Backpressure: pixel 0xBEEF, ready_i low for 3 cycles while 0xBE is presented -> 0xBE held stable with valid_o=1 and ready_o=0 throughout, then BE, EF complete.
- msb_first_p=0, P=3, pixel 0x112233 -> bytes 33,22,11, with last_o only on 0x11.
- Async reset asserted after 0xAA of pixel 0xAA55 -> valid_o and busy_o drop without a clock edge. After release 0x55 is never emitted and ready_o=1.
- P=1, random valid_i/ready_i over 1000 cycles -> output byte sequence equals the accepted pixel sequence, last_o=1 on every beat, no loss or duplication (scoreboard).
